pipe_io_ports: RTL and testbench

Memory-mapped I/O responder for the pipelined CPU: it serves loads and stores that the MEM stage directs at the I/O window instead of data memory. It synchronizes and debounces the two 4-bit switch inputs and holds two 32-bit output registers. A sequential binary-to-BCD converter drives the two active-low 7-segment digits from `out_port0`. It is the CPU-side counterpart of the switch/display stimulus that the system bench applies to `pipelined_computer`.

---
 rtl/pipe_io_pkg.sv | 51 +++++
 rtl/pipe_io_ports_debounce.sv | 49 ++++
 rtl/pipe_io_ports.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_io_ports.sv | 522 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_io_pkg.sv
// Shared definitions for the pipelined CPU I/O window.
// Holds the register offsets, the converter state type and the 7-segment
// patterns that other display logic also uses.
package pipe_io_pkg;

    // Word offsets inside the 32-byte I/O window (io_addr[4:2])
    localparam logic [2:0] OFF_IN0  = 3'd0;
    localparam logic [2:0] OFF_IN1  = 3'd1;
    localparam logic [2:0] OFF_OUT0 = 3'd2;
    localparam logic [2:0] OFF_OUT1 = 3'd3;
    localparam logic [2:0] OFF_STAT = 3'd4;

    // Binary-to-BCD converter states
    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_e;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Decimal digit to segment pattern; non-decimal codes show a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/pipe_io_ports_debounce.sv
// Switch input conditioner: two-flop synchronizer followed by a debouncer.
// The stable value only follows the synchronized input after it has
// disagreed with the stable value for DB_LIMIT consecutive cycles. A
// different mismatching value arriving mid-count keeps the count going;
// only agreement with the stable value restarts it. 'update' is high in
// the cycle whose clock edge loads a new stable value.
module io_debounce #(
    parameter int DB_LIMIT = 50000,
    parameter int DB_W     = 16,
    parameter int W        = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] stable,
    output logic         update
);

    localparam logic [DB_W-1:0] LIMIT_M1 = DB_W'(DB_LIMIT - 1);

    logic [W-1:0]    sync1;
    logic [W-1:0]    sync2;
    logic [DB_W-1:0] cnt;

    // Stable value is about to change: mismatch held for the full window
    assign update = (sync2 != stable) && (cnt == LIMIT_M1);

    // Synchronize the raw input and count consecutive mismatching cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LIMIT_M1) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_io_ports.sv
// Memory-mapped I/O responder for the pipelined CPU MEM stage.
// Serves two debounced 4-bit switch ports, two 32-bit output registers,
// a status word, and drives two 7-segment digits from out_port0[7:0]
// through a sequential double-dabble converter.
//
// Bus strobes: io_we and io_re are per-cycle strobes that only count
// when io_sel is high. A store takes effect at the clock edge that ends
// the cycle; a load is answered combinationally in the same cycle and
// its only side effect is clearing the matching in-port changed flag at
// that edge. A load and store to the same offset in one cycle return the
// old contents.
module pipe_io_ports
    import pipe_io_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = 32'h0000_0080,
    parameter int          DB_LIMIT = 50000,
    parameter int          DB_W     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    input  logic [3:0]  in_port0,
    input  logic [3:0]  in_port1,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output conv_state_e dbg_conv_state
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [2:0] offset;
    logic       wr_en;
    logic       rd_en;
    logic       unused_addr_bits;

    assign io_sel           = (io_addr[31:5] == IO_BASE[31:5]);
    assign offset           = io_addr[4:2];
    assign wr_en            = io_sel & io_we;
    assign rd_en            = io_sel & io_re;
    // Byte lane bits are irrelevant: every register is word-wide
    assign unused_addr_bits = ^io_addr[1:0];

    // ------------------------------------------------------------------
    // Input ports
    // ------------------------------------------------------------------
    logic [3:0] in0_stable;
    logic [3:0] in1_stable;
    logic       in0_update;
    logic       in1_update;
    logic       in0_changed;
    logic       in1_changed;

    io_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .DB_W     (DB_W),
        .W        (4)
    ) u_db0 (
        .clock  (clock),
        .reset  (reset),
        .din    (in_port0),
        .stable (in0_stable),
        .update (in0_update)
    );

    io_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .DB_W     (DB_W),
        .W        (4)
    ) u_db1 (
        .clock  (clock),
        .reset  (reset),
        .din    (in_port1),
        .stable (in1_stable),
        .update (in1_update)
    );

    // Changed flags: a new stable value sets, a load of the port clears,
    // and a set in the same cycle as the clearing load wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in0_changed <= 1'b0;
            in1_changed <= 1'b0;
        end else begin
            if (in0_update) begin
                in0_changed <= 1'b1;
            end else if (rd_en && (offset == OFF_IN0)) begin
                in0_changed <= 1'b0;
            end
            if (in1_update) begin
                in1_changed <= 1'b1;
            end else if (rd_en && (offset == OFF_IN1)) begin
                in1_changed <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic wr_out0;
    logic wr_out1;

    assign wr_out0 = wr_en && (offset == OFF_OUT0);
    assign wr_out1 = wr_en && (offset == OFF_OUT1);

    // Stores land at the clock edge; stores to read-only offsets fall away
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_port0 <= '0;
            out_port1 <= '0;
        end else begin
            if (wr_out0) begin
                out_port0 <= io_wdata;
            end
            if (wr_out1) begin
                out_port1 <= io_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Binary-to-BCD converter and segment decode
    // ------------------------------------------------------------------
    conv_state_e conv_state;
    logic [7:0]  conv_bin;
    logic [11:0] conv_bcd;
    logic [3:0]  conv_cnt;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_next;
    logic [7:0]  bin_next;
    logic        conv_busy;

    assign conv_busy      = (conv_state == CONV_SHIFT);
    assign dbg_conv_state = conv_state;

    // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin}
    always_comb begin
        bcd_adj = conv_bcd;
        for (int i = 0; i < 3; i++) begin
            if (conv_bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[10:0], conv_bin[7]};
        bin_next = {conv_bin[6:0], 1'b0};
    end

    // Converter FSM: eight shift cycles per out0 store, digits latched on
    // the last one so the display never shows a partial result
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conv_state <= CONV_IDLE;
            conv_bin   <= '0;
            conv_bcd   <= '0;
            conv_cnt   <= '0;
            hex0       <= SEG_0;
            hex1       <= SEG_0;
        end else if (wr_out0) begin
            conv_state <= CONV_SHIFT;
            conv_bin   <= io_wdata[7:0];
            conv_bcd   <= '0;
            conv_cnt   <= 4'd8;
        end else if (conv_state == CONV_SHIFT) begin
            conv_bin <= bin_next;
            conv_bcd <= bcd_next;
            conv_cnt <= conv_cnt - 4'd1;
            if (conv_cnt == 4'd1) begin
                conv_state <= CONV_IDLE;
                if (bcd_next[11:8] != 4'd0) begin
                    hex0 <= SEG_DASH;
                    hex1 <= SEG_DASH;
                end else begin
                    hex0 <= seg_decode(bcd_next[3:0]);
                    hex1 <= seg_decode(bcd_next[7:4]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Combinational load data; zero outside the window and at offsets 5-7
    always_comb begin
        io_rdata = '0;
        if (io_sel) begin
            case (offset)
                OFF_IN0:  io_rdata = {28'd0, in0_stable};
                OFF_IN1:  io_rdata = {28'd0, in1_stable};
                OFF_OUT0: io_rdata = out_port0;
                OFF_OUT1: io_rdata = out_port1;
                OFF_STAT: io_rdata = {29'd0, in1_changed, in0_changed, conv_busy};
                default:  io_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_io_ports.sv
// Self-checking bench for pipe_io_ports with DB_LIMIT = 2.
module tb_pipe_io_ports;
    import pipe_io_pkg::*;

    localparam logic [31:0] BASE     = 32'h0000_0080;
    localparam int          DB_LIMIT = 2;

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_we;
    logic        io_re;
    logic        io_sel;
    logic [31:0] io_rdata;
    logic [3:0]  in_port0;
    logic [3:0]  in_port1;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    conv_state_e dbg_conv_state;

    int checks   = 0;
    int failures = 0;

    // expected display state kept by the bench
    logic [6:0]  exp_hex0;
    logic [6:0]  exp_hex1;
    logic [31:0] exp_out0;
    logic [31:0] exp_out1;
    logic [31:0] exp_q[$];

    pipe_io_ports #(
        .IO_BASE  (BASE),
        .DB_LIMIT (DB_LIMIT),
        .DB_W     (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_addr        (io_addr),
        .io_wdata       (io_wdata),
        .io_we          (io_we),
        .io_re          (io_re),
        .io_sel         (io_sel),
        .io_rdata       (io_rdata),
        .in_port0       (in_port0),
        .in_port1       (in_port1),
        .out_port0      (out_port0),
        .out_port1      (out_port1),
        .hex0           (hex0),
        .hex1           (hex1),
        .dbg_conv_state (dbg_conv_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference helpers ----------------
    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // expected display for a stored byte: decimal digits, dash at >= 100
    task automatic display_of(input logic [7:0] v, output logic [6:0] h1, output logic [6:0] h0);
        int n;
        n = int'(v);
        if (n >= 100) begin
            h1 = 7'b0111111;
            h0 = 7'b0111111;
        end else begin
            h1 = exp_seg(n / 10);
            h0 = exp_seg(n % 10);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        io_addr  = a;
        io_wdata = d;
        io_we    = 1'b1;
        cyc();
        io_we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d);
        io_addr = a;
        io_re   = 1'b1;
        #1;
        d = io_rdata;
        cyc();
        io_re = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        io_addr = a;
        io_re   = 1'b0;
        #1;
        d = io_rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (out_port0 !== 32'd0) begin
            failures++;
            $display("FAIL reset_out0: got %h expected 0", out_port0);
        end
        checks++;
        if (out_port1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_out1: got %h expected 0", out_port1);
        end
        checks++;
        if (hex0 !== 7'b1000000 || hex1 !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_hex: got %b/%b expected 1000000/1000000", hex1, hex0);
        end
        checks++;
        if (dbg_conv_state !== CONV_IDLE) begin
            failures++;
            $display("FAIL reset_state: got %0d expected idle", dbg_conv_state);
        end
        peek(BASE + 32'h10, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL reset_status: got %h expected 0", d);
        end
        exp_hex0 = 7'b1000000;
        exp_hex1 = 7'b1000000;
        exp_out0 = 32'd0;
        exp_out1 = 32'd0;
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        in_port0 = 4'd15;
        repeat (3) cyc();
        peek(BASE, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL db_early: got %h expected 0", d);
        end
        cyc();
        peek(BASE, d);
        checks++;
        if (d !== 32'd15) begin
            failures++;
            $display("FAIL db_accept: got %h expected 15", d);
        end
        peek(BASE + 32'h10, d);
        checks++;
        if (d[1] !== 1'b1) begin
            failures++;
            $display("FAIL db_flag_set: got %b expected 1", d[1]);
        end
        do_load(BASE, d);
        checks++;
        if (d !== 32'd15) begin
            failures++;
            $display("FAIL db_load: got %h expected 15", d);
        end
        peek(BASE + 32'h10, d);
        checks++;
        if (d[1] !== 1'b0) begin
            failures++;
            $display("FAIL db_flag_clear: got %b expected 0", d[1]);
        end
        // one-cycle glitch must be rejected
        in_port0 = 4'd3;
        cyc();
        in_port0 = 4'd15;
        for (int i = 0; i < 6; i++) begin
            cyc();
            peek(BASE, d);
            checks++;
            if (d !== 32'd15) begin
                failures++;
                $display("FAIL db_glitch cycle %0d: got %h expected 15", i, d);
            end
        end
        peek(BASE + 32'h10, d);
        checks++;
        if (d[1] !== 1'b0) begin
            failures++;
            $display("FAIL db_glitch_flag: got %b expected 0", d[1]);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        in_port1 = 4'd9;
        repeat (3) cyc();
        // this cycle's edge both accepts the new value and loads offset 1
        io_addr = BASE + 32'h4;
        io_re   = 1'b1;
        cyc();
        io_re = 1'b0;
        peek(BASE + 32'h10, d);
        checks++;
        if (d[2] !== 1'b1) begin
            failures++;
            $display("FAIL simul_set_wins: got %b expected 1", d[2]);
        end
        peek(BASE + 32'h4, d);
        checks++;
        if (d !== 32'd9) begin
            failures++;
            $display("FAIL simul_value: got %h expected 9", d);
        end
        do_load(BASE + 32'h4, d);
        peek(BASE + 32'h10, d);
        checks++;
        if (d[2] !== 1'b0) begin
            failures++;
            $display("FAIL simul_clear: got %b expected 0", d[2]);
        end
    endtask

    // Behavioural model: the switch value seen two edges ago must disagree
    // with the shown value for DB_LIMIT edges in a row to be accepted.
    logic [3:0] m_seen1, m_seen2, m_shown;
    int         m_streak;
    logic       m_flag;

    task automatic model_edge(input logic [3:0] v);
        if (m_seen2 != m_shown) begin
            m_streak++;
            if (m_streak >= DB_LIMIT) begin
                m_shown  = m_seen2;
                m_streak = 0;
                m_flag   = 1'b1;
            end
        end else begin
            m_streak = 0;
        end
        m_seen2 = m_seen1;
        m_seen1 = v;
    endtask

    task automatic test_debounce_random();
        logic [31:0] d;
        logic [3:0]  val;
        int          hold;
        m_seen1  = 4'd9;
        m_seen2  = 4'd9;
        m_shown  = 4'd9;
        m_streak = 0;
        m_flag   = 1'b0;
        val      = 4'd9;
        hold     = 0;
        for (int i = 0; i < 40; i++) begin
            if (hold == 0) begin
                val  = 4'($urandom_range(0, 15));
                hold = int'($urandom_range(1, 3));
            end
            hold--;
            in_port1 = val;
            cyc();
            model_edge(val);
            peek(BASE + 32'h4, d);
            checks++;
            if (d !== {28'd0, m_shown}) begin
                failures++;
                $display("FAIL db_rand step %0d: got %h expected %h", i, d, m_shown);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            model_edge(val);
        end
        peek(BASE + 32'h10, d);
        checks++;
        if (d[2] !== m_flag) begin
            failures++;
            $display("FAIL db_rand_flag: got %b expected %b", d[2], m_flag);
        end
        do_load(BASE + 32'h4, d);
        checks++;
        if (d !== {28'd0, val}) begin
            failures++;
            $display("FAIL db_rand_settle: got %h expected %h", d, val);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] d;
        logic [31:0] r;
        do_store(BASE + 32'hC, 32'hDEADBEEF);
        exp_out1 = 32'hDEADBEEF;
        checks++;
        if (out_port1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL st_out1: got %h expected deadbeef", out_port1);
        end
        do_load(BASE + 32'hC, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL ld_out1: got %h expected deadbeef", d);
        end
        // read-only offsets ignore stores
        do_store(BASE, $urandom);
        do_store(BASE + 32'h10, 32'hFFFF_FFFF);
        peek(BASE, d);
        checks++;
        if (d !== 32'd15) begin
            failures++;
            $display("FAIL st_readonly_in0: got %h expected 15", d);
        end
        peek(BASE + 32'h10, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL st_readonly_stat: got %h expected 0", d);
        end
        // outside the window
        do_store(32'h48, 32'h1234_5678);
        io_addr = 32'h40;
        #1;
        checks++;
        if (io_sel !== 1'b0 || io_rdata !== 32'd0) begin
            failures++;
            $display("FAIL outside_window: got sel=%b data=%h expected sel=0 data=0", io_sel, io_rdata);
        end
        checks++;
        if (out_port0 !== exp_out0 || dbg_conv_state !== CONV_IDLE) begin
            failures++;
            $display("FAIL outside_store: got out0=%h expected %h", out_port0, exp_out0);
        end
        for (int k = 5; k < 8; k++) begin
            peek(BASE + 32'(4 * k), d);
            checks++;
            if (d !== 32'd0) begin
                failures++;
                $display("FAIL unused_offset %0d: got %h expected 0", k, d);
            end
        end
        // load and store together: load sees the old word
        io_addr  = BASE + 32'hC;
        io_wdata = 32'hCAFE_F00D;
        io_we    = 1'b1;
        io_re    = 1'b1;
        #1;
        checks++;
        if (io_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL ld_st_same: got %h expected deadbeef", io_rdata);
        end
        cyc();
        io_we = 1'b0;
        io_re = 1'b0;
        exp_out1 = 32'hCAFE_F00D;
        peek(BASE + 32'hC, d);
        checks++;
        if (d !== exp_out1) begin
            failures++;
            $display("FAIL ld_after_st: got %h expected %h", d, exp_out1);
        end
        // randomized store/load with byte-lane address noise
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            do_store(BASE + 32'hC + 32'($urandom_range(0, 3)), r);
            exp_q.push_back(r);
            exp_out1 = r;
            do_load(BASE + 32'hC + 32'($urandom_range(0, 3)), d);
            r = exp_q.pop_front();
            checks++;
            if (d !== r) begin
                failures++;
                $display("FAIL rand_ld %0d: got %h expected %h", i, d, r);
            end
        end
    endtask

    task automatic convert_check(input logic [31:0] v);
        logic [31:0] d;
        logic [6:0]  n1, n0;
        display_of(v[7:0], n1, n0);
        do_store(BASE + 32'h8, v);
        exp_out0 = v;
        checks++;
        if (out_port0 !== v) begin
            failures++;
            $display("FAIL conv_out0: got %h expected %h", out_port0, v);
        end
        for (int k = 0; k < 8; k++) begin
            peek(BASE + 32'h10, d);
            checks++;
            if (d[0] !== 1'b1 || hex0 !== exp_hex0 || hex1 !== exp_hex1) begin
                failures++;
                $display("FAIL conv_busy v=%0d k=%0d: got busy=%b hex=%b/%b expected busy=1 hex=%b/%b",
                         v[7:0], k, d[0], hex1, hex0, exp_hex1, exp_hex0);
            end
            cyc();
        end
        exp_hex0 = n0;
        exp_hex1 = n1;
        peek(BASE + 32'h10, d);
        checks++;
        if (d[0] !== 1'b0 || hex0 !== exp_hex0 || hex1 !== exp_hex1) begin
            failures++;
            $display("FAIL conv_done v=%0d: got busy=%b hex=%b/%b expected busy=0 hex=%b/%b",
                     v[7:0], d[0], hex1, hex0, exp_hex1, exp_hex0);
        end
    endtask

    task automatic test_conversion();
        convert_check(32'd42);
        convert_check(32'd99);
        convert_check(32'd100);
        for (int i = 0; i < 5; i++) begin
            convert_check($urandom);
        end
    endtask

    task automatic test_restart();
        logic [31:0] d;
        do_store(BASE + 32'h8, 32'd57);
        repeat (3) cyc();
        do_store(BASE + 32'h8, 32'd13);
        exp_out0 = 32'd13;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (hex0 !== exp_hex0 || hex1 !== exp_hex1) begin
                failures++;
                $display("FAIL restart_hold k=%0d: got %b/%b expected %b/%b", k, hex1, hex0, exp_hex1, exp_hex0);
            end
            cyc();
        end
        exp_hex1 = 7'b1111001;
        exp_hex0 = 7'b0110000;
        peek(BASE + 32'h10, d);
        checks++;
        if (hex1 !== exp_hex1 || hex0 !== exp_hex0 || d[0] !== 1'b0) begin
            failures++;
            $display("FAIL restart_result: got %b/%b busy=%b expected %b/%b busy=0",
                     hex1, hex0, d[0], exp_hex1, exp_hex0);
        end
    endtask

    task automatic test_reset_midconv();
        logic [31:0] d;
        do_store(BASE + 32'h8, 32'd77);
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        checks++;
        if (dbg_conv_state !== CONV_IDLE || out_port0 !== 32'd0 || out_port1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_conv: got state=%0d out0=%h out1=%h expected idle/0/0",
                     dbg_conv_state, out_port0, out_port1);
        end
        checks++;
        if (hex0 !== 7'b1000000 || hex1 !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_mid_hex: got %b/%b expected 1000000/1000000", hex1, hex0);
        end
        peek(BASE, d);
        checks++;
        if (d !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_in0: got %h expected 0", d);
        end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset    = 1'b1;
        io_addr  = 32'd0;
        io_wdata = 32'd0;
        io_we    = 1'b0;
        io_re    = 1'b0;
        in_port0 = 4'd0;
        in_port1 = 4'd0;
        test_reset();
        test_debounce();
        test_simultaneous();
        test_debounce_random();
        test_store_load();
        test_conversion();
        test_restart();
        test_reset_midconv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
